// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared EXU constants: divider op-vector bit indices and FSM states
package exu_pkg;

   localparam int DIV_OP_DIV   = 0;
   localparam int DIV_OP_DIVU  = 1;
   localparam int DIV_OP_REM   = 2;
   localparam int DIV_OP_REMU  = 3;
   localparam int DIV_OP_DIVW  = 4;
   localparam int DIV_OP_DIVUW = 5;
   localparam int DIV_OP_REMW  = 6;
   localparam int DIV_OP_REMUW = 7;

   // Mask of the op-vector bits that select 32-bit (W) operation.
   localparam logic [7:0] DIV_OP_W = 8'b1111_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration on a {rem,quo} partial remainder
module div_step #(
   parameter int XLEN = 64
) (
   input  logic [2*XLEN-1:0] pr_i,
   input  logic [XLEN-1:0]   divisor_i,
   output logic [2*XLEN-1:0] pr_o
);

   // Shifted remainder needs one extra bit: it can exceed 2^XLEN-1 before the subtract.
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;
   logic            no_borrow;

   always_comb begin
      rem_sh    = pr_i[2*XLEN-1:XLEN-1];
      no_borrow = (rem_sh >= {1'b0, divisor_i});
      diff      = rem_sh[XLEN-1:0] - divisor_i;
      pr_o      = {(no_borrow ? diff : rem_sh[XLEN-1:0]), pr_i[XLEN-2:0], no_borrow};
   end

endmodule

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - iterative radix-2 restoring divider for the RV64M div/rem group
module divider_iter
   import exu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            div_flush,
   input  logic            div_in_valid,
   output logic            div_in_ready,
   input  logic [7:0]      div_op,
   input  logic [XLEN-1:0] div_src1,
   input  logic [XLEN-1:0] div_src2,
   output logic            div_out_valid,
   input  logic            div_out_ready,
   output logic [XLEN-1:0] div_result
);

   localparam int CW = $clog2(XLEN) + 1;

   div_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] pr_q, pr_d, pr_step;
   logic [XLEN-1:0]   dvsr_q, dvsr_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              is_w_q, is_w_d;
   logic              is_rem_q, is_rem_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;

   logic              accept;
   logic              op_w, op_rem, op_signed;
   logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, ovf_pat;
   logic              sign_a, sign_b, div_zero, ovf;
   logic [XLEN-1:0]   q_raw, r_raw, q_fin, r_fin, calc_res;

   // W results are always sign-extended from bit 31, even for the unsigned ops.
   function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] v, input logic w);
      fmt_w = w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   assign div_in_ready  = (state_q == IDLE) && !div_flush;
   assign div_out_valid = (state_q == DONE);
   assign div_result    = result_q;
   assign accept        = div_in_valid && div_in_ready;

   assign op_w      = |(div_op & DIV_OP_W);
   assign op_rem    = div_op[DIV_OP_REM] | div_op[DIV_OP_REMU] |
                      div_op[DIV_OP_REMW] | div_op[DIV_OP_REMUW];
   assign op_signed = div_op[DIV_OP_DIV] | div_op[DIV_OP_REM] |
                      div_op[DIV_OP_DIVW] | div_op[DIV_OP_REMW];

   // Operands are widened to XLEN first so signed/unsigned and W/full share one path.
   always_comb begin
      a_ext    = op_w ? {{(XLEN-32){op_signed & div_src1[31]}}, div_src1[31:0]} : div_src1;
      b_ext    = op_w ? {{(XLEN-32){op_signed & div_src2[31]}}, div_src2[31:0]} : div_src2;
      sign_a   = op_signed & a_ext[XLEN-1];
      sign_b   = op_signed & b_ext[XLEN-1];
      mag_a    = sign_a ? -a_ext : a_ext;
      mag_b    = sign_b ? -b_ext : b_ext;
      ovf_pat  = op_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (b_ext == '0);
      ovf      = op_signed && (a_ext == ovf_pat) && (&b_ext);
   end

   div_step #(.XLEN(XLEN)) u_step (
      .pr_i      (pr_q),
      .divisor_i (dvsr_q),
      .pr_o      (pr_step)
   );

   always_comb begin
      q_raw    = pr_step[XLEN-1:0];
      r_raw    = pr_step[2*XLEN-1:XLEN];
      q_fin    = neg_quo_q ? -q_raw : q_raw;
      r_fin    = neg_rem_q ? -r_raw : r_raw;
      calc_res = fmt_w(is_rem_q ? r_fin : q_fin, is_w_q);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pr_d      = pr_q;
      dvsr_d    = dvsr_q;
      result_d  = result_q;
      is_w_d    = is_w_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               is_w_d    = op_w;
               is_rem_d  = op_rem;
               neg_quo_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               dvsr_d    = mag_b;
               // W dividends sit at the top of the quotient half so 32 shifts consume them.
               pr_d      = op_w ? {{XLEN{1'b0}}, mag_a[31:0], {(XLEN-32){1'b0}}}
                                : {{XLEN{1'b0}}, mag_a};
               cnt_d     = op_w ? CW'(32) : CW'(XLEN);
               if (div_zero) begin
                  result_d = fmt_w(op_rem ? a_ext : {XLEN{1'b1}}, op_w);
                  state_d  = DONE;
               end else if (ovf) begin
                  result_d = op_rem ? '0 : fmt_w(a_ext, op_w);
                  state_d  = DONE;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            pr_d  = pr_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               result_d = calc_res;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (div_out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (div_flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pr_q      <= '0;
         dvsr_q    <= '0;
         result_q  <= '0;
         is_w_q    <= 1'b0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pr_q      <= pr_d;
         dvsr_q    <= dvsr_d;
         result_q  <= result_d;
         is_w_q    <= is_w_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule

// File: tb/tb_divider_iter.sv
// tb/tb_divider_iter.sv - scoreboard bench for divider_iter with directed vectors
module tb_divider_iter;

   localparam int XLEN = 64;
   localparam logic [7:0] OP_DIV = 8'h01, OP_DIVU = 8'h02, OP_REM = 8'h04, OP_REMU = 8'h08;
   localparam logic [7:0] OP_DIVW = 8'h10, OP_DIVUW = 8'h20, OP_REMW = 8'h40, OP_REMUW = 8'h80;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            div_flush = 1'b0;
   logic            div_in_valid = 1'b0;
   logic            div_in_ready;
   logic [7:0]      div_op = OP_DIV;
   logic [XLEN-1:0] div_src1 = '0;
   logic [XLEN-1:0] div_src2 = '0;
   logic            div_out_valid;
   logic            div_out_ready = 1'b1;
   logic [XLEN-1:0] div_result;

   typedef struct {
      string       name;
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   bit   seen = 1'b1;

   divider_iter #(.XLEN(XLEN)) dut (
      .clk           (clk),
      .rst           (rst),
      .div_flush     (div_flush),
      .div_in_valid  (div_in_valid),
      .div_in_ready  (div_in_ready),
      .div_op        (div_op),
      .div_src1      (div_src1),
      .div_src2      (div_src2),
      .div_out_valid (div_out_valid),
      .div_out_ready (div_out_ready),
      .div_result    (div_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: timestamps accepts and pops the scoreboard on each new result.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (div_in_valid) begin
         assert ($onehot(div_op)) else $error("div_op not one-hot: %b", div_op);
      end
      if (div_in_valid && div_in_ready && !rst) begin
         acc_cyc = cyc;
         seen = 1'b0;
      end
      if (div_out_valid && !seen) begin
         seen = 1'b1;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got result %h want no output", div_result);
         end else begin
            e = sb.pop_front();
            chk(e.name, div_result, e.res);
            chk({e.name, "_lat"}, 64'(cyc - acc_cyc), 64'(e.lat));
         end
      end
   end

   task automatic issue(input string name, input logic [7:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat,
                        input bit push);
      int n = 0;
      @(posedge clk); #1;
      div_op = op;
      div_src1 = a;
      div_src2 = b;
      div_in_valid = 1'b1;
      if (push) sb.push_back('{name, exp, lat});
      @(negedge clk);
      while (!div_in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk({name, "_accept_timeout"}, 64'(div_in_ready), 64'd1);
      @(posedge clk); #1;
      div_in_valid = 1'b0;
      div_src1 = {$urandom, $urandom};
      div_src2 = {$urandom, $urandom};
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk({name, "_result_timeout"}, 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input string name, input logic [7:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input int lat);
      issue(name, op, a, b, exp, lat, 1'b1);
      drain(name);
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (!div_out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!div_out_valid) chk({name, "_valid_timeout"}, 64'(div_out_valid), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(div_in_ready), 64'd1);
      chk("rst_out_valid", 64'(div_out_valid), 64'd0);
      chk("rst_result", div_result, 64'd0);

      run("divu_100_7",   OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
      run("remu_100_7",   OP_REMU, 64'd100, 64'd7, 64'd2, 65);
      run("div_m7_2",     OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      run("rem_m7_2",     OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65);
      run("div_7_m2",     OP_DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      run("rem_7_m2",     OP_REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
      run("divu_max_3",   OP_DIVU, ONES, 64'd3, 64'h5555_5555_5555_5555, 65);
      run("divu_5_0",     OP_DIVU, 64'd5, 64'd0, ONES, 1);
      run("rem_5_0",      OP_REM,  64'd5, 64'd0, 64'd5, 1);
      run("div_ovf",      OP_DIV,  64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1);
      run("rem_ovf",      OP_REM,  64'h8000_0000_0000_0000, ONES, 64'd0, 1);
      run("divw_ovf",     OP_DIVW, 64'h0000_0001_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1);
      run("divuw_max_1",  OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 33);
      run("remuw_max_16", OP_REMUW, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 33);
      run("divuw_big_2",  OP_DIVUW, 64'hABCD_0000_8000_0000, 64'd2, 64'h4000_0000, 33);
      run("divw_m7_2",    OP_DIVW, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
      run("remw_m7_2",    OP_REMW, 64'h1234_5678_FFFF_FFF9, 64'd2, ONES, 33);
      run("divw_zero",    OP_DIVW, 64'd7, 64'h0000_0001_0000_0000, ONES, 1);
      run("remuw_zero",   OP_REMUW, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1);

      // Backpressure: result held in DONE while the consumer stalls.
      div_out_ready = 1'b0;
      issue("bp_divu", OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b1);
      wait_out("bp");
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid", 64'(div_out_valid), 64'd1);
         chk("bp_result", div_result, 64'd14);
         chk("bp_in_ready", 64'(div_in_ready), 64'd0);
      end
      @(posedge clk); #1 div_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 64'(div_in_ready), 64'd1);
      chk("bp_release_valid", 64'(div_out_valid), 64'd0);
      drain("bp");

      // Flush mid-CALC with a competing request in the flush cycle.
      issue("fl_divu", OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b0);
      repeat (19) @(posedge clk);
      #1;
      div_flush = 1'b1;
      div_in_valid = 1'b1;
      div_op = OP_DIVU;
      div_src1 = 64'd1;
      div_src2 = 64'd1;
      @(negedge clk);
      chk("fl_in_ready_low", 64'(div_in_ready), 64'd0);
      @(posedge clk); #1;
      div_flush = 1'b0;
      div_in_valid = 1'b0;
      @(negedge clk);
      chk("fl_out_valid", 64'(div_out_valid), 64'd0);
      chk("fl_in_ready", 64'(div_in_ready), 64'd1);
      repeat (70) @(negedge clk);
      run("fl_divu_9_3", OP_DIVU, 64'd9, 64'd3, 64'd3, 65);

      // Flush in DONE discards the pending result.
      div_out_ready = 1'b0;
      issue("fd_divu", OP_DIVU, 64'd9, 64'd3, 64'd3, 65, 1'b1);
      wait_out("fd");
      @(posedge clk); #1 div_flush = 1'b1;
      @(posedge clk); #1 div_flush = 1'b0;
      @(negedge clk);
      chk("fd_out_valid", 64'(div_out_valid), 64'd0);
      chk("fd_in_ready", 64'(div_in_ready), 64'd1);
      div_out_ready = 1'b1;
      drain("fd");

      // Reset mid-CALC.
      issue("rs_divu", OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b0);
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rs_in_ready", 64'(div_in_ready), 64'd1);
      chk("rs_out_valid", 64'(div_out_valid), 64'd0);
      chk("rs_result", div_result, 64'd0);
      repeat (70) @(negedge clk);
      run("rs_divu_9_3", OP_DIVU, 64'd9, 64'd3, 64'd3, 65);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/divider_iter.md
Name: divider_iter

Overview:
- Multi-cycle radix-2 restoring divider for the RV64M divide/remainder group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits in the EXU alongside the combinational ALU and shifter.
- Uses the same one-hot op-vector style as the shifter.
- Uses a valid/ready handshake on both sides so the pipeline can stall on it.
- Computes one quotient bit per cycle. Divide-by-zero and signed overflow take a one-cycle fast path.

Parameters:
- XLEN, 64, operand/result width; W ops always operate on bits [31:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- div_flush  in  1  abort any in-flight operation (pipeline flush)
- div_in_valid  in  1  operands/op valid
- div_in_ready  out  1  divider can accept
- div_op  in  8  one-hot op: [0]div [1]divu [2]rem [3]remu [4]divw [5]divuw [6]remw [7]remuw
- div_src1  in  XLEN  dividend
- div_src2  in  XLEN  divisor
- div_out_valid  out  1  result valid
- div_out_ready  in  1  consumer accepts result
- div_result  out  XLEN  quotient or remainder

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous and active-high.
- Reset: state=IDLE, div_in_ready=1, div_out_valid=0, div_result=0, counter=0.
- States:
  - IDLE: div_in_ready=1. Accept when div_in_valid&div_in_ready; latch op, signs and magnitudes. Go to DONE if the op is a special case, else CALC.
  - CALC: div_in_ready=0. Each cycle: partial remainder {rem,quo} shifts left 1; subtract divisor magnitude if no borrow; set quotient LSB. Counter counts down from N (64, or 32 for W ops). Go to DONE after the N-th iteration.
  - DONE: div_out_valid=1; div_result is stable and held while div_out_ready=0. Go to IDLE on div_out_ready.
- Latency: accept in cycle T gives div_out_valid in cycle T+N+1, i.e. T+65 (64-bit) or T+33 (W). Special cases give div_out_valid in T+1.
- Throughput: no overlap. div_in_ready=0 from the cycle after accept until the cycle after the output handshake.
- Width rules:
  - W ops take src[31:0]. Signed W ops sign-extend it; unsigned W ops zero-extend it.
  - The 32-bit result is always sign-extended from bit 31 into [63:32], including divuw and remuw.
- Signed ops: divide magnitudes. Negate the quotient if sign1^sign2. Negate the remainder if sign1 is set.
- Divide by zero (divisor bits within the op width are zero): quotient = all ones (W: 0xFFFFFFFF sign-extended); remainder = dividend (W: src1[31:0] sign-extended).
- Signed overflow (div/rem: 0x8000_0000_0000_0000 / -1; divw/remw: 0x8000_0000 / -1): quotient = dividend (W sign-extended), remainder = 0.
- div_flush:
  - Priority below rst, above everything else.
  - The next state is IDLE and div_out_valid=0 in the following cycle.
  - A div_in_valid in the same cycle is not accepted; div_in_ready is forced low that cycle.
  - In DONE it discards the pending result.
- div_out_ready while not in DONE is ignored.
- div_op must be one-hot when div_in_valid=1. The bench asserts this. The RTL is not required to handle violations.
- Operand changes on the inputs after accept have no effect.

Decomposition:
- Shared package (exu_pkg): op-bit index constants DIV_OP_DIV..DIV_OP_REMUW, DIV_OP_W, and state encodings IDLE/CALC/DONE.
- Sub-module div_step: combinational single-iteration shift/subtract on a (2*XLEN)-bit partial remainder. It is instantiated once inside divider_iter.

Test Plan:
- divu 100/7 accepted at cycle T -> div_out_valid at T+65, div_result=14. Then remu 100/7 -> 2.
- div src1=-7 (0xFFFF_FFFF_FFFF_FFF9), src2=2 -> 0xFFFF_FFFF_FFFF_FFFD. rem on the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- Special cases:
  - divu 5/0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1.
  - rem 5/0 -> 5.
  - div 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000.
  - rem on the same operands -> 0.
- W ops:
  - divw src1=0x0000_0001_8000_0000, src2=-1 -> 0xFFFF_FFFF_8000_0000 at T+1.
  - divuw 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF at T+33.
  - remuw 0xFFFF_FFFF/0x10 -> 0x0000_0000_0000_000F.
- Backpressure: hold div_out_ready=0 for 10 cycles in DONE -> div_out_valid and div_result stay stable and div_in_ready stays 0. Then raise div_out_ready -> IDLE next cycle with div_in_ready=1.
- Flush and reset:
  - div_flush at iteration 20 of divu 100/7 -> IDLE next cycle, no div_out_valid.
  - A new divu 9/3 then returns 3 at its own T+65.
  - rst mid-CALC behaves identically and restores all reset values.
